modport_tap: RTL and testbench

IEEE 1149.1-style TAP slave that implements the slave side of the JTAG link: it samples `tdi`/`tms` and returns `tdo`. It sits behind the chip's JTAG pins and contains:
- the 16-state TAP controller;
- a 4-bit instruction register;
- three data registers: BYPASS, IDCODE and a 32-bit read/write USER register.

It is driven by the JTAG master agent and watched by the JTAG monitor.

---
 rtl/modport_tap_if.sv | 8 +
 rtl/modport_tap.sv | 84 ++++++++
 tb/tb_modport_tap.sv | 130 +++++++++++++
 3 files changed

// File: rtl/modport_tap_if.sv
// modport_tap_if: JTAG serial link between master agent and TAP slave
interface modport_tap_if;
  logic tdi;
  logic tms;
  logic tdo;
  modport master (output tdi, output tms, input tdo);
  modport slave (input tdi, input tms, output tdo);
endinterface

// File: rtl/modport_tap.sv
// modport_tap: IEEE 1149.1-style TAP slave with IR, BYPASS, IDCODE and USER registers
module modport_tap #(
  parameter logic [31:0] IDCODE_VAL = 32'h0ABC_D123,
  parameter int IR_W = 4,
  parameter int USER_W = 32
) (
  input  logic              tck,
  input  logic              trst,
  modport_tap_if.slave      jtag,
  output logic [3:0]        tap_state,
  output logic [IR_W-1:0]   ir_q,
  output logic [USER_W-1:0] user_q
);
  typedef enum logic [3:0] {
    TLR = 4'hF, RTI = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAUSE_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAUSE_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } state_t;
  state_t state, nxt;
  logic [IR_W-1:0] ir_sr;
  logic [31:0] id_sr;
  logic [USER_W-1:0] user_sr;
  logic byp_sr, sel_id, sel_user, sel_byp, tdo_d;
  assign tap_state = state;
  assign sel_id = ir_q == IR_W'(4'b0001);
  assign sel_user = ir_q == IR_W'(4'b1000);
  assign sel_byp = !sel_id && !sel_user;
  always_comb begin
    nxt = TLR;
    case (state)
      TLR:      nxt = jtag.tms ? TLR    : RTI;
      RTI:      nxt = jtag.tms ? SEL_DR : RTI;
      SEL_DR:   nxt = jtag.tms ? SEL_IR : CAP_DR;
      CAP_DR:   nxt = jtag.tms ? EX1_DR : SH_DR;
      SH_DR:    nxt = jtag.tms ? EX1_DR : SH_DR;
      EX1_DR:   nxt = jtag.tms ? UPD_DR : PAUSE_DR;
      PAUSE_DR: nxt = jtag.tms ? EX2_DR : PAUSE_DR;
      EX2_DR:   nxt = jtag.tms ? UPD_DR : SH_DR;
      UPD_DR:   nxt = jtag.tms ? SEL_DR : RTI;
      SEL_IR:   nxt = jtag.tms ? TLR    : CAP_IR;
      CAP_IR:   nxt = jtag.tms ? EX1_IR : SH_IR;
      SH_IR:    nxt = jtag.tms ? EX1_IR : SH_IR;
      EX1_IR:   nxt = jtag.tms ? UPD_IR : PAUSE_IR;
      PAUSE_IR: nxt = jtag.tms ? EX2_IR : PAUSE_IR;
      EX2_IR:   nxt = jtag.tms ? UPD_IR : SH_IR;
      UPD_IR:   nxt = jtag.tms ? SEL_DR : RTI;
      default:  nxt = TLR;
    endcase
  end
  always_ff @(posedge tck)
    if (!trst) begin
      state <= TLR;
      ir_q <= IR_W'(4'b0001);
      user_q <= '0;
      ir_sr <= '0;
      id_sr <= '0;
      user_sr <= '0;
      byp_sr <= 1'b0;
    end else begin
      state <= nxt;
      if (state == CAP_IR) ir_sr <= IR_W'(4'b0101);
      if (state == SH_IR) ir_sr <= {jtag.tdi, ir_sr[IR_W-1:1]};
      if (state == UPD_IR) ir_q <= ir_sr;
      if (nxt == TLR) ir_q <= IR_W'(4'b0001);
      if (state == CAP_DR) begin
        if (sel_id) id_sr <= IDCODE_VAL;
        if (sel_user) user_sr <= user_q;
        if (sel_byp) byp_sr <= 1'b0;
      end
      if (state == SH_DR) begin
        if (sel_id) id_sr <= {jtag.tdi, id_sr[31:1]};
        if (sel_user) user_sr <= {jtag.tdi, user_sr[USER_W-1:1]};
        if (sel_byp) byp_sr <= jtag.tdi;
      end
      if (state == UPD_DR && sel_user) user_q <= user_sr;
    end
  // tdo is launched half a cycle early so the master sees it at the next rising edge
  always_comb
    tdo_d = state == SH_IR ? ir_sr[0] :
            state == SH_DR ? (sel_id ? id_sr[0] : sel_user ? user_sr[0] : byp_sr) : 1'b0;
  always_ff @(negedge tck) jtag.tdo <= tdo_d;
endmodule

// File: tb/tb_modport_tap.sv
// tb_modport_tap: directed and randomized JTAG scans against a scan-level reference model
module tb_modport_tap;
  localparam logic [31:0] IDV = 32'h0ABC_D123;
  logic tck = 1'b0;
  logic trst;
  logic [3:0] st;
  logic [3:0] ir;
  logic [31:0] usr;
  modport_tap_if j();
  modport_tap dut (.tck(tck), .trst(trst), .jtag(j), .tap_state(st), .ir_q(ir), .user_q(usr));
  always #5 tck = ~tck;
  int passed = 0, total = 0;
  logic [3:0] nx0 [16];
  logic [3:0] nx1 [16];
  logic [3:0] exp_st = 4'hF;
  logic [3:0] exp_ir = 4'h1;
  logic [31:0] exp_user = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic step(input bit m, input bit d, output bit o);
    @(negedge tck);
    #1 j.tms = m;
    j.tdi = d;
    o = j.tdo;
    if (exp_st != 4'hA && exp_st != 4'h2) chk("tdo_idle", {31'b0, o}, 32'b0);
    @(posedge tck);
    #1 exp_st = m ? nx1[exp_st] : nx0[exp_st];
    if (exp_st == 4'hF) exp_ir = 4'h1;
    chk("tap_state", {28'b0, st}, {28'b0, exp_st});
  endtask
  task automatic rst_cycle(input bit m);
    @(negedge tck);
    #1 trst = 1'b0;
    j.tms = m;
    @(posedge tck);
    #1 exp_st = 4'hF;
    exp_ir = 4'h1;
    exp_user = '0;
    chk("rst_state", {28'b0, st}, 32'hF);
    chk("rst_ir", {28'b0, ir}, 32'h1);
  endtask
  task automatic scan_ir(input logic [3:0] v);
    bit o;
    logic [3:0] out;
    step(1, 0, o); step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < 4; i++) begin
      step(i == 3, v[i], o);
      out[i] = o;
    end
    step(1, 0, o); step(0, 0, o);
    exp_ir = v;
    chk("ir_capture", {28'b0, out}, 32'h5);
    chk("ir_q", {28'b0, ir}, {28'b0, exp_ir});
  endtask
  // Any register of length L: output bit i is the captured bit i, then tdi delayed by L
  task automatic scan_dr(input int n, input logic [31:0] d);
    bit o;
    int len;
    logic [31:0] cap, out, exp;
    len = (exp_ir == 4'h1 || exp_ir == 4'h8) ? 32 : 1;
    cap = exp_ir == 4'h1 ? IDV : exp_ir == 4'h8 ? exp_user : 32'h0;
    out = '0;
    exp = '0;
    step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, d[i], o);
      out[i] = o;
    end
    step(1, 0, o); step(0, 0, o);
    for (int i = 0; i < n; i++)
      if (i < len) exp[i] = cap[i];
      else exp[i] = d[i-len];
    if (exp_ir == 4'h8 && n == 32) exp_user = d;
    chk("dr_out", out, exp);
    chk("user_q", usr, exp_user);
  endtask
  initial begin
    bit o;
    logic [3:0] rir;
    logic [31:0] rd;
    nx0 = '{4'h2, 4'h3, 4'h2, 4'h3, 4'hE, 4'hC, 4'h2, 4'h6, 4'hA, 4'hB, 4'hA, 4'hB, 4'hC, 4'hC, 4'hA, 4'hC};
    nx1 = '{4'h5, 4'h5, 4'h1, 4'h0, 4'hF, 4'h7, 4'h1, 4'h4, 4'hD, 4'hD, 4'h9, 4'h8, 4'h7, 4'h7, 4'h9, 4'hF};
    trst = 1'b0;
    j.tms = 1'b0;
    j.tdi = 1'b0;
    rst_cycle(0);
    rst_cycle(1);
    chk("rst_user", usr, 32'h0);
    @(negedge tck);
    #1 chk("rst_tdo", {31'b0, j.tdo}, 32'h0);
    trst = 1'b1;
    step(0, 0, o);
    scan_dr(32, $urandom);
    scan_ir(4'h8);
    scan_dr(32, 32'hDEAD_BEEF);
    scan_dr(32, $urandom);
    scan_ir(4'h6);
    scan_dr(8, 32'hA5);
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 3))
        0: rir = 4'h1;
        1: rir = 4'h8;
        2: rir = 4'hF;
        default: rir = 4'($urandom);
      endcase
      scan_ir(rir);
      scan_dr((rir == 4'h1 || rir == 4'h8) ? 32 : int'($urandom_range(1, 32)), $urandom);
    end
    scan_ir(4'h8);
    scan_dr(32, $urandom);
    scan_ir(4'hF);
    step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < 5; i++) step(1, 1'($urandom), o);
    chk("tlr_ir", {28'b0, ir}, 32'h1);
    chk("tlr_user", usr, exp_user);
    step(0, 0, o);
    scan_ir(4'h8);
    step(1, 0, o); step(0, 0, o); step(0, 0, o);
    for (int i = 0; i < 5; i++) step(0, 1'($urandom), o);
    rst_cycle(0);
    trst = 1'b1;
    step(0, 0, o);
    scan_dr(32, $urandom);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
